// File: rtl/pipe_skid_reg32_if.sv
// Valid/ready handshake bundle for pipe_skid_reg32: producer side (in_*) and consumer side (out_*).
interface pipe_skid_reg32_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  // Environment side: drives the producer and consumer stages.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  // Register side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/pipe_skid_reg32.sv
// Two-entry elastic pipeline register (main + skid) with registered in_ready,
// full 1 word/cycle throughput and synchronous flush.
module pipe_skid_reg32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  pipe_skid_reg32_if.slave         bus,
  output logic [1:0]               count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             load_main_in, load_main_skid, load_skid;
  logic             in_xfer, out_xfer;

  // All outputs decode from registers only; no input reaches an output combinationally.
  always_comb begin
    bus.out_valid = (state_q != EMPTY);
    bus.in_ready  = (state_q != FULL);
    bus.out_data  = main_q;
    count         = state_q;
  end

  assign in_xfer  = bus.in_valid  & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            load_main_in = 1'b1;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            load_main_in = 1'b1;
          end else if (in_xfer) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            load_main_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= bus.in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg32.sv
// Directed bench for pipe_skid_reg32: stream, backpressure, drain, flush and async reset.
module tb_pipe_skid_reg32;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [1:0] count;
  int unsigned errors;
  int unsigned checks;

  pipe_skid_reg32_if #(.WIDTH(32)) bus ();

  pipe_skid_reg32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [1:0] exp_count,
                             input logic exp_valid, input logic exp_ready);
    check({tag, ".count"},     {30'd0, count},         {30'd0, exp_count});
    check({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, exp_valid});
    check({tag, ".in_ready"},  {31'd0, bus.in_ready},  {31'd0, exp_ready});
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    #2;
    check_state("reset", 2'd0, 1'b0, 1'b1);
    check("reset.out_data", bus.out_data, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Streaming: each word appears one edge after acceptance.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("stream%0d.data", i), bus.out_data, 32'(i));
      check_state($sformatf("stream%0d", i), 2'd1, 1'b1, 1'b1);
      bus.in_data = 32'(i + 1);
    end
    bus.in_valid = 1'b0;
    tick();
    check_state("stream_end", 2'd0, 1'b0, 1'b1);

    // Backpressure fill.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hAAAA0000;
    tick();
    check_state("fill1", 2'd1, 1'b1, 1'b1);
    check("fill1.data", bus.out_data, 32'hAAAA0000);
    bus.in_data = 32'hBBBB0000;
    tick();
    check_state("fill2", 2'd2, 1'b1, 1'b0);
    check("fill2.data", bus.out_data, 32'hAAAA0000);
    bus.in_data = 32'hCCCC0000;
    tick();
    check_state("held_off", 2'd2, 1'b1, 1'b0);
    check("held_off.data", bus.out_data, 32'hAAAA0000);

    // Drain with no gap; CCCC enters as BBBB leaves.
    bus.out_ready = 1'b1;
    tick();
    check_state("drain1", 2'd1, 1'b1, 1'b1);
    check("drain1.data", bus.out_data, 32'hBBBB0000);
    tick();
    check_state("drain2", 2'd1, 1'b1, 1'b1);
    check("drain2.data", bus.out_data, 32'hCCCC0000);
    bus.in_valid = 1'b0;
    tick();
    check_state("drain3", 2'd0, 1'b0, 1'b1);
    check("drain3.hold_data", bus.out_data, 32'hCCCC0000);

    // Simultaneous input and output in ONE.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h12345678;
    tick();
    check("one.data", bus.out_data, 32'h12345678);
    bus.in_data   = 32'h9ABCDEF0;
    bus.out_ready = 1'b1;
    tick();
    check_state("passthru", 2'd1, 1'b1, 1'b1);
    check("passthru.data", bus.out_data, 32'h9ABCDEF0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    check_state("stall", 2'd1, 1'b1, 1'b1);
    check("stall.data", bus.out_data, 32'h9ABCDEF0);

    // Flush while FULL with concurrent in_valid.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h11111111;
    tick();
    check_state("full_pre_flush", 2'd2, 1'b1, 1'b0);
    flush       = 1'b1;
    bus.in_data = 32'h22222222;
    tick();
    check_state("flush_full", 2'd0, 1'b0, 1'b1);
    flush       = 1'b0;
    bus.in_data = 32'h33333333;
    tick();
    check_state("post_flush", 2'd1, 1'b1, 1'b1);
    check("post_flush.data", bus.out_data, 32'h33333333);

    // Flush in ONE discards the concurrent input word.
    flush       = 1'b1;
    bus.in_data = 32'h44444444;
    tick();
    check_state("flush_one", 2'd0, 1'b0, 1'b1);
    check("flush_one.data", bus.out_data, 32'h33333333);
    flush = 1'b0;

    // Refill to FULL, then asynchronous reset between edges.
    bus.in_data = 32'h55555555;
    tick();
    bus.in_data = 32'h66666666;
    tick();
    bus.in_valid = 1'b0;
    check_state("full_pre_reset", 2'd2, 1'b1, 1'b0);
    check("full_pre_reset.data", bus.out_data, 32'h55555555);
    #3 rst_n = 1'b0;
    #1;
    check_state("async_reset", 2'd0, 1'b0, 1'b1);
    check("async_reset.data", bus.out_data, 32'h0);
    #2 rst_n = 1'b1;
    tick();
    check_state("after_reset", 2'd0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg32.md
Name: pipe_skid_reg32

Overview:
- Elastic valid/ready pipeline register that sits between two multi-cycle datapath stages, such as ALU result to writeback.
- Unlike the plain unconditional capture flop, it honours consumer backpressure, so no word is lost when the downstream stage stalls.
- Holds up to 2 words (main + skid) and sustains 1 word/cycle with fully registered in_ready.

Parameters:
WIDTH, 32, data path width in bits

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous flush; discards all held words
in_data  input  WIDTH  producer data
in_valid  input  1  producer has a word this cycle
in_ready  output  1  block can accept a word (registered)
out_data  output  WIDTH  word presented to consumer (registered)
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts out_data this cycle
count  output  2  words held: 0, 1 or 2

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Transfers:
  - Input transfer = in_valid & in_ready at a rising edge.
  - Output transfer = out_valid & out_ready at a rising edge.
- Reset (rst_n low, asynchronous):
  - state EMPTY, out_valid=0, in_ready=1, count=0.
  - out_data=0; internal skid data=0.
- States and outputs:
  - EMPTY (count 0): out_valid=0, in_ready=1.
  - ONE (count 1): out_valid=1, in_ready=1, out_data=main.
  - FULL (count 2): out_valid=1, in_ready=0, out_data=main, skid holds the next word.
- Transitions (flush=0):
  - EMPTY: input transfer -> main<=in_data, ONE. Otherwise stay.
  - ONE, input and output transfer together -> main<=in_data, stay ONE.
  - ONE, input transfer only -> skid<=in_data, FULL.
  - ONE, output transfer only -> EMPTY.
  - ONE, neither -> hold.
  - FULL, output transfer -> main<=skid, ONE.
  - FULL, no output transfer -> hold.
  - No input transfer is possible in FULL, because in_ready=0.
- Latency and throughput:
  - Word accepted at edge N appears on out_data with out_valid=1 after edge N. It is consumable at edge N+1 at the earliest.
  - Back-to-back throughput is 1 word/cycle while out_ready=1.
- Ordering: strict FIFO order; words are never duplicated or reordered.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid are held constant.
- in_ready timing: registered. in_ready = (next state != FULL). It never depends combinationally on out_ready or in_valid.
- Flush:
  - flush=1 at an edge -> EMPTY, out_valid=0, in_ready=1, count=0. This overrides everything else.
  - Any input transfer in the same cycle is discarded.
  - Data registers are not cleared.
- Values when idle:
  - in_data is ignored when no input transfer occurs.
  - out_data is don't-care when out_valid=0, but it holds the last value and is not randomized.
- Reset mid-operation: any held words are lost immediately, asynchronously; outputs take reset values.
- Timing: no combinational path from any input to any output.

Test Plan:
- Reset then stream: rst_n low 3 cycles, release, out_ready=1, drive 0x00000001..0x00000008 on consecutive cycles -> out_data 0x1..0x8 each one cycle later, in_ready constantly 1, count 1 throughout.
- Backpressure fill: out_ready=0, send 0xAAAA0000 then 0xBBBB0000 -> count 0->1->2, in_ready=0 after the second edge. A third word 0xCCCC0000 is held off by in_valid=1 with no transfer. out_data stays 0xAAAA0000.
- Drain after stall: from FULL raise out_ready=1 with 0xCCCC0000 waiting -> outputs 0xAAAA0000, 0xBBBB0000, 0xCCCC0000 on three consecutive edges with no gap. in_ready returns 1 one cycle after the first drain.
- Simultaneous in/out in ONE: hold 0x12345678, assert in_valid with 0x9ABCDEF0 and out_ready=1 same cycle -> next cycle out_data=0x9ABCDEF0, count=1, no skid use.
- Flush while FULL with concurrent in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1. No flushed or concurrent word ever appears on out_data.
- Async reset mid-stall: FULL state, pull rst_n low between edges -> out_valid=0, in_ready=1, count=0, out_data=0 immediately, without waiting for a clk edge.
